serial_adder_ctrl: RTL

//   Bit-serial add controller that drives the single-bit full-adder sum cell.

---
 rtl/serial_adder_ctrl_if.sv | 31 +++
 rtl/serial_adder_ctrl.sv | 103 ++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl_if.sv
// rtl/serial_adder_ctrl_if.sv - request/result and sum-cell signal bundle for serial_adder_ctrl
// The sub port exists only when SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_ctrl_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic             fa_x;
  logic             fa_y;
  logic             fa_cin;
  logic             fa_r;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

`ifdef SERIAL_ADDER_SUB_EN
  modport master (output start, a, b, cin, sub, fa_r,
                  input  fa_x, fa_y, fa_cin, busy, done, sum, cout);
  modport slave  (input  start, a, b, cin, sub, fa_r,
                  output fa_x, fa_y, fa_cin, busy, done, sum, cout);
`else
  modport master (output start, a, b, cin, fa_r,
                  input  fa_x, fa_y, fa_cin, busy, done, sum, cout);
  modport slave  (input  start, a, b, cin, fa_r,
                  output fa_x, fa_y, fa_cin, busy, done, sum, cout);
`endif
endinterface

// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial add controller driving an external full-adder sum cell
// Optional subtract mode under SERIAL_ADDER_SUB_EN (adds bus.sub).
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_adder_ctrl_if.slave  bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, sum_sh, sum_q;
  logic             carry, cout_q;
  logic [CW-1:0]    cnt;
  logic             accept, last, carry_nxt;
  logic [WIDTH-1:0] b_sel;
  logic             cin_sel;

`ifdef SERIAL_ADDER_SUB_EN
  // a - b computed as a + ~b + 1
  assign b_sel   = bus.sub ? ~bus.b : bus.b;
  assign cin_sel = bus.sub | bus.cin;
`else
  assign b_sel   = bus.b;
  assign cin_sel = bus.cin;
`endif

  assign carry_nxt = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
  assign bus.sum   = sum_q;
  assign bus.cout  = cout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    last       = 1'b0;
    bus.busy   = 1'b0;
    bus.done   = 1'b0;
    bus.fa_x   = 1'b0;
    bus.fa_y   = 1'b0;
    bus.fa_cin = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        bus.busy   = 1'b1;
        bus.fa_x   = a_sh[0];
        bus.fa_y   = b_sh[0];
        bus.fa_cin = carry;
        if (cnt == CW'(WIDTH - 1)) begin
          last      = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        bus.done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else if (accept) begin
      a_sh   <= bus.a;
      b_sh   <= b_sel;
      carry  <= cin_sel;
      cnt    <= '0;
      sum_sh <= '0;
    end else if (state == RUN) begin
      sum_sh <= {bus.fa_r, sum_sh[WIDTH-1:1]};
      carry  <= carry_nxt;
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      cnt    <= last ? '0 : cnt + 1'b1;
      if (last) begin
        sum_q  <= {bus.fa_r, sum_sh[WIDTH-1:1]};
        cout_q <= carry_nxt;
      end
    end
  end

endmodule
